fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 32, meaning the instruction memory size in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 SHALL have port stall, input, 1 bit, a request to hold the fetch and decode stages.
REQ-006 SHALL have port flush, input, 1 bit, a request to redirect the PC to br_target (taken branch or jump).
REQ-007 SHALL have port br_target, input, 32 bits, the redirect address.
REQ-008 SHALL have port pc_f, output, 32 bits, the fetch address driven to the instruction memory addr input.
REQ-009 SHALL have port inst_i, input, 32 bits, the combinational instruction returned for pc_f.
REQ-010 SHALL have ports pc_d and inst_d, output, 32 bits each: the IF/ID register contents.
REQ-011 SHALL have port valid_d, output, 1 bit, meaning inst_d holds a real instruction.
REQ-012 SHALL have ports halted and fault, output, 1 bit each: halt reached, and halt caused by an error.
REQ-013 SHALL have ports fetch_cnt and stall_cnt, output, 32 bits each: performance counters.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and HALT; rst forces IDLE; IDLE moves to RUN after exactly 1 cycle, with pc_f held.
REQ-015 In RUN, SHALL apply flush > stall > advance priority each cycle.
REQ-016 On flush: pc_f <= {br_target[31:2],2'b00}; inst_d <= NOP (32'h0000_0013); valid_d <= 0; pc_d unchanged.
REQ-017 On stall without flush: pc_f, pc_d, inst_d and valid_d all hold their values.
REQ-018 On advance: pc_d <= pc_f; inst_d <= inst_i; valid_d <= 1; pc_f <= pc_f+4 (32-bit wrap).
REQ-019 Fetch-to-decode latency SHALL be 1 cycle: the instruction at pc_f appears on inst_d on the next edge.
REQ-020 On advance with inst_i equal to ECALL (32'h0000_0073) or EBREAK (32'h0010_0073): the instruction SHALL still be registered with valid_d=1, and the state goes to HALT.
REQ-021 A flush in the same cycle as a fetched ECALL/EBREAK SHALL win; no halt occurs.
REQ-022 In RUN with no flush and pc_f >= IMEM_DEPTH*4: SHALL go to HALT with fault=1, valid_d <= 0, and inst_d <= NOP.
REQ-023 In HALT: pc_f SHALL hold; valid_d SHALL be 0 from the cycle after entry; halted=1; stall and flush are ignored; the only exit is rst.
REQ-024 halted SHALL be a registered output equal to (state==HALT); fault is sticky until rst.

Reset
REQ-025 SHALL apply the following on rst=1 at the edge, overriding all other inputs:
- pc_f=RESET_PC, pc_d=0, inst_d=NOP
- valid_d=0, halted=0, fault=0
- fetch_cnt=0, stall_cnt=0, state=IDLE
REQ-026 SHALL discard any in-progress flush or halt entry when rst is asserted mid-operation.

Configuration
REQ-027 SHALL gate the performance counters with macro FETCH_PERF_CNT_EN, as follows:
- Defined: fetch_cnt increments on each advance cycle; stall_cnt increments on each RUN cycle with stall=1 and flush=0; both saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Structure
REQ-028 SHALL place in shared package fetch_pkg:
- the state enum
- NOP_INST, ECALL_INST and EBREAK_INST constants
REQ-029 SHALL place the counters in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-030 Reset, then 3 free cycles with imem words 0x00500093, 0x00100113, 0x00000013 -> pc_f sequence 0, 0, 4, 8, 12; inst_d shows each word 1 cycle after its fetch; valid_d=1 from cycle 2.
REQ-031 stall=1 for 2 cycles at pc_f=8 -> pc_f, pc_d and inst_d are frozen; with macro defined, stall_cnt=2.
REQ-032 flush=1 with stall=1 and br_target=0x0000_0013 at pc_f=12 -> next pc_f=0x10, valid_d=0, inst_d=NOP.
REQ-033 ECALL at address 0x14 -> inst_d=0x00000073 with valid_d=1; halted=1 on the next cycle; pc_f stays 0x18; later flush pulses are ignored.
REQ-034 Run sequentially to pc_f=0x80 (IMEM_DEPTH=32) -> HALT with fault=1 and valid_d=0; rst then restores pc_f=0, halted=0, fault=0.
REQ-035 Assert rst in the same cycle as a fetched EBREAK -> state IDLE, halted stays 0, all outputs at reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Optional feature macro used by this slice: FETCH_PERF_CNT_EN (performance counters).
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    // True for instructions that stop the fetch stream.
    function automatic logic is_halt_inst(input logic [31:0] inst);
        return (inst == ECALL_INST) || (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch/stall performance counters for the fetch stage.
// Instantiated by fetch_controller only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    // Count qualifying cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_inc && (fetch_cnt != '1))
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, IF/ID register, halt detection.
// Optional macro FETCH_PERF_CNT_EN enables the fetch/stall performance counters;
// without it fetch_cnt and stall_cnt are constant zero.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] br_target,
    output logic [31:0] pc_f,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_d,
    output logic [31:0] inst_d,
    output logic        valid_d,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    // 33-bit limit so IMEM_DEPTH*4 cannot overflow the comparison.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

    fetch_state_t state;
    logic         in_run;
    logic         out_of_range;
    logic         advance;

    // Per-cycle decisions in RUN: flush beats the range fault, which beats stall.
    always_comb begin
        in_run       = (state == RUN);
        out_of_range = ({1'b0, pc_f} >= PC_LIMIT);
        advance      = in_run && !flush && !out_of_range && !stall;
    end

    // Fetch FSM with registered PC, IF/ID register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc_f    <= RESET_PC;
            pc_d    <= '0;
            inst_d  <= NOP_INST;
            valid_d <= 1'b0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (flush) begin
                        pc_f    <= br_target & 32'hFFFF_FFFC;
                        inst_d  <= NOP_INST;
                        valid_d <= 1'b0;
                    end else if (out_of_range) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        fault   <= 1'b1;
                        inst_d  <= NOP_INST;
                        valid_d <= 1'b0;
                    end else if (!stall) begin
                        pc_d    <= pc_f;
                        inst_d  <= inst_i;
                        valid_d <= 1'b1;
                        pc_f    <= pc_f + 32'd4;
                        if (is_halt_inst(inst_i)) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    valid_d <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;

    // A stall cycle is counted only when no flush overrides it.
    always_comb begin
        stall_cycle = in_run && stall && !flush;
    end

    fetch_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (advance),
        .stall_inc (stall_cycle),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
